bp_fe_branch_resolve_queue: RTL and testbench
=============================================

# bp_fe_branch_resolve_queue

Branch resolution queue that produces the BHT write stream. The fetch side enqueues every BHT prediction, with its table index and predicted direction, and receives a slot id. The backend later resolves branches by id, in any order. The queue retires resolved entries strictly in program order. Each retirement is one BHT update (valid, index, correct, predicted-taken) presented on a valid/ready port. A mispredict discards all younger entries.

## Interface
- bht_idx_width_p, "inv": BHT index width; must match the BHT instance.
- els_p, 8: queue depth; power of two, ≥2.
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- pred_v_i  in  1  enqueue request.
- pred_idx_i  in  bht_idx_width_p  BHT index used for the prediction.
- pred_taken_i  in  1  predicted direction.
- pred_ready_o  out  1  queue not full; enqueue occurs on pred_v_i & pred_ready_o.
- pred_id_o  out  lg(els_p)  slot id assigned to the current enqueue (tail index).
- res_v_i  in  1  resolution valid.
- res_id_i  in  lg(els_p)  slot being resolved.
- res_taken_i  in  1  actual direction.
- flush_i  in  1  discard all entries.
- upd_v_o  out  1  head entry is resolved; BHT update available.
- upd_idx_o  out  bht_idx_width_p  head index.
- upd_correct_o  out  1  1 when actual direction == predicted direction.
- upd_pred_taken_o  out  1  head predicted direction.
- upd_ready_i  in  1  consumer accepts; retire on upd_v_o & upd_ready_i.
- count_o  out  lg(els_p)+1  occupancy.

## Operation
- **Storage**: els_p entries of {idx, pred_taken, resolved, res_taken}.
- **Pointers**: head and tail are lg(els_p)+1 bits, with a wrap bit.
  - Empty: head == tail.
  - Full: low bits equal and wrap bits differ.
- **Enqueue**: writes the tail entry with resolved=0, then increments tail.
  - pred_id_o = tail low bits, always driven.
  - pred_ready_o = !full.
- **Resolve**: if the slot is occupied and not yet resolved, set resolved=1 and res_taken=res_taken_i.
  - A resolve to an unoccupied slot is ignored.
  - A resolve to an already-resolved slot is ignored; the first resolution wins.
- **Mispredict** (accepted resolve with res_taken_i != stored pred_taken):
  - tail ← head + ((res_id_i − head) mod els_p) + 1, with the wrap bit computed consistently.
  - The resolved entry stays; all younger entries are discarded.
  - A same-cycle enqueue is discarded even if pred_v_i & pred_ready_o.
- **Retire**:
  - upd_v_o = !empty & head.resolved.
  - upd_correct_o = head.res_taken ~^ head.pred_taken.
  - Head increments on handshake.
  - Outputs come from registered state only; no combinational path from res_* to upd_*.
- **Flush**: next cycle head = tail = 0 and all resolved bits are cleared.
  - A retire handshaked in the same cycle counts as delivered.
  - A same-cycle enqueue or resolve is dropped.
- **Simultaneous events**:
  - Enqueue, resolve, and retire may all occur in one cycle.
  - Enqueue is allowed while full only if a same-cycle retire frees a slot? No: pred_ready_o depends on the registered full state only.
- **Reset**: head = tail = 0 and all resolved bits cleared.
  - pred_ready_o=1, pred_id_o=0, upd_v_o=0, upd_idx_o=0, upd_correct_o=0, upd_pred_taken_o=0, count_o=0.
  - Reset mid-operation discards all contents with no update emitted.

## Timing
- Enqueue at cycle t: the entry is resolvable at t+1, and count_o reflects it at t+1.
- Resolve of the head at cycle t: upd_v_o=1 at t+1.
- Resolve at t followed by retire at t+1: the BHT sees the update at t+1.
- Throughput: one enqueue, one resolve, and one retire per cycle.
- Mispredict truncation is visible in count_o and pred_id_o at t+1.
- Flush takes effect at t+1.

## Structure
- bht_idx_width_p and els_p flow from the existing FE parameter set.
- The entry struct is declared in-module because it is width-parameterized; no new typedefs go into bp_fe_pkg.
- One sub-module, bp_fe_brq_ptr: wrap-bit pointer with increment and load. It is instantiated twice, for head and tail.

## Test plan
1. **Fill and full**: reset, enqueue 8 entries with idx 0x10..0x17.
   - pred_ready_o=0 and count_o=8.
   - pred_id_o equals 0..7 at the respective enqueues.
2. **Out-of-order resolve**: resolve ids 2, 1, 0 in order, each correct.
   - upd_v_o stays 0 until id 0 resolves.
   - Then updates retire at idx 0x10, 0x11, 0x12, one per cycle, with upd_correct_o=1.
3. **Mispredict squash**: 5 entries queued, head=0; resolve id 1 mispredicted while enqueueing.
   - count_o=2 next cycle and the same-cycle enqueue is dropped.
   - Retire id 1 shows upd_correct_o=0.
4. **Wrap-around**: with head=6 and 4 entries (ids 6, 7, 0, 1), mispredict on id 7.
   - The tail becomes slot 0 with the wrap bit flipped, and count_o=2.
5. **Flush and backpressure**: hold upd_ready_i=0 with the head resolved, then pulse flush_i.
   - upd_v_o=0 and count_o=0 next cycle; no update is emitted.
6. **Invalid resolves**: resolve an empty slot, then resolve the same id twice.
   - The state is unchanged and the first res_taken value is kept.

Source files
------------

// File: rtl/bp_fe_branch_resolve_queue_pkg.sv
// Shared defaults and small helpers for the branch resolution queue.
package bp_fe_branch_resolve_queue_pkg;

  localparam int brq_bht_idx_width_c = 8;
  localparam int brq_els_c           = 8;

  // BHT "correct" bit: actual direction matches the predicted direction.
  function automatic logic brq_correct(input logic res_taken, input logic pred_taken);
    return res_taken ~^ pred_taken;
  endfunction

endpackage

// File: rtl/bp_fe_branch_resolve_queue_if.sv
// Fetch/backend/BHT-update signal bundle of the branch resolution queue.
interface bp_fe_branch_resolve_queue_if #(
  parameter int bht_idx_width_p = bp_fe_branch_resolve_queue_pkg::brq_bht_idx_width_c,
  parameter int els_p           = bp_fe_branch_resolve_queue_pkg::brq_els_c
);
  localparam int lg_els_lp = $clog2(els_p);

  logic                       pred_v_i;
  logic [bht_idx_width_p-1:0] pred_idx_i;
  logic                       pred_taken_i;
  logic                       pred_ready_o;
  logic [lg_els_lp-1:0]       pred_id_o;

  logic                       res_v_i;
  logic [lg_els_lp-1:0]       res_id_i;
  logic                       res_taken_i;
  logic                       flush_i;

  logic                       upd_v_o;
  logic [bht_idx_width_p-1:0] upd_idx_o;
  logic                       upd_correct_o;
  logic                       upd_pred_taken_o;
  logic                       upd_ready_i;
  logic [lg_els_lp:0]         count_o;

  // Queue side
  modport slave (
    input  pred_v_i, pred_idx_i, pred_taken_i,
    output pred_ready_o, pred_id_o,
    input  res_v_i, res_id_i, res_taken_i, flush_i,
    output upd_v_o, upd_idx_o, upd_correct_o, upd_pred_taken_o,
    input  upd_ready_i,
    output count_o
  );

  // Fetch / backend / BHT side
  modport master (
    output pred_v_i, pred_idx_i, pred_taken_i,
    input  pred_ready_o, pred_id_o,
    output res_v_i, res_id_i, res_taken_i, flush_i,
    input  upd_v_o, upd_idx_o, upd_correct_o, upd_pred_taken_o,
    output upd_ready_i,
    input  count_o
  );
endinterface

// File: rtl/bp_fe_brq_ptr.sv
// Wrap-bit queue pointer: lg(els_p) slot bits plus one wrap bit, with increment and load.
module bp_fe_brq_ptr #(
  parameter int els_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   inc_i,
  input  logic                   load_i,
  input  logic [$clog2(els_p):0] load_val_i,
  output logic [$clog2(els_p):0] ptr_o
);

  // Load has priority over increment; the wrap bit falls out of the natural carry.
  always_ff @(posedge clk_i) begin
    if (reset_i)     ptr_o <= '0;
    else if (load_i) ptr_o <= load_val_i;
    else if (inc_i)  ptr_o <= ptr_o + 1'b1;
  end

endmodule

// File: rtl/bp_fe_branch_resolve_queue.sv
// Branch resolution queue: in-order retirement of out-of-order resolved BHT
// predictions, producing one BHT update per retired entry.
module bp_fe_branch_resolve_queue
  import bp_fe_branch_resolve_queue_pkg::*;
#(
  parameter int bht_idx_width_p = brq_bht_idx_width_c,
  parameter int els_p           = brq_els_c
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  bp_fe_branch_resolve_queue_if.slave brq
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int ptr_w_lp  = lg_els_lp + 1;

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic                       pred_taken;
    logic                       resolved;
    logic                       res_taken;
  } entry_s;

  entry_s mem_r [els_p];

  logic [ptr_w_lp-1:0]  head_r, tail_r, count, tail_trunc;
  logic [lg_els_lp-1:0] head_lo, tail_lo, res_off;
  logic                 full, empty, enq, res_occ, res_acc, mispred, retire;
  entry_s               head_e, res_e;

  assign head_lo = head_r[lg_els_lp-1:0];
  assign tail_lo = tail_r[lg_els_lp-1:0];
  assign empty   = (head_r == tail_r);
  assign full    = (head_lo == tail_lo) && (head_r[lg_els_lp] != tail_r[lg_els_lp]);
  assign count   = tail_r - head_r;

  assign head_e  = mem_r[head_lo];
  assign res_e   = mem_r[brq.res_id_i];

  // A slot is occupied when its distance from head is below the occupancy.
  assign res_off    = brq.res_id_i - head_lo;
  assign res_occ    = ({1'b0, res_off} < count);
  assign res_acc    = brq.res_v_i & res_occ & ~res_e.resolved & ~brq.flush_i;
  assign mispred    = res_acc & (brq.res_taken_i != res_e.pred_taken);
  // Truncate just past the mispredicted slot; full-width add keeps the wrap bit consistent.
  assign tail_trunc = head_r + {1'b0, res_off} + 1'b1;

  assign enq    = brq.pred_v_i & ~full & ~brq.flush_i & ~mispred;
  assign retire = brq.upd_v_o & brq.upd_ready_i;

  bp_fe_brq_ptr #(.els_p(els_p)) head_ptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (retire),
    .load_i     (brq.flush_i),
    .load_val_i ('0),
    .ptr_o      (head_r)
  );

  bp_fe_brq_ptr #(.els_p(els_p)) tail_ptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .inc_i      (enq),
    .load_i     (brq.flush_i | mispred),
    .load_val_i (brq.flush_i ? '0 : tail_trunc),
    .ptr_o      (tail_r)
  );

  // Entry storage: resolved bits are control and get cleared; payload fields are not reset.
  always_ff @(posedge clk_i) begin
    if (reset_i || brq.flush_i) begin
      for (int i = 0; i < els_p; i++) mem_r[i].resolved <= 1'b0;
    end else begin
      if (enq) begin
        mem_r[tail_lo].idx        <= brq.pred_idx_i;
        mem_r[tail_lo].pred_taken <= brq.pred_taken_i;
        mem_r[tail_lo].resolved   <= 1'b0;
        mem_r[tail_lo].res_taken  <= 1'b0;
      end
      if (res_acc) begin
        mem_r[brq.res_id_i].resolved  <= 1'b1;
        mem_r[brq.res_id_i].res_taken <= brq.res_taken_i;
      end
    end
  end

  assign brq.pred_ready_o     = ~full;
  assign brq.pred_id_o        = tail_lo;
  assign brq.count_o          = count;
  // Update fields are zero when no update is offered so idle outputs stay clean.
  assign brq.upd_v_o          = ~empty & head_e.resolved;
  assign brq.upd_idx_o        = brq.upd_v_o ? head_e.idx : '0;
  assign brq.upd_correct_o    = brq.upd_v_o & brq_correct(head_e.res_taken, head_e.pred_taken);
  assign brq.upd_pred_taken_o = brq.upd_v_o & head_e.pred_taken;

endmodule

// File: tb/tb_bp_fe_branch_resolve_queue.sv
// Directed bench for the branch resolution queue.
module tb_bp_fe_branch_resolve_queue;

  localparam int W  = 8;
  localparam int EL = 8;

  logic clk_i;
  logic reset_i;
  int   checks = 0;
  int   errors = 0;

  bp_fe_branch_resolve_queue_if #(.bht_idx_width_p(W), .els_p(EL)) bus ();

  bp_fe_branch_resolve_queue #(.bht_idx_width_p(W), .els_p(EL)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .brq     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.pred_v_i = 0; bus.pred_idx_i = '0; bus.pred_taken_i = 0;
    bus.res_v_i = 0; bus.res_id_i = '0; bus.res_taken_i = 0;
    bus.flush_i = 0;
  endtask

  task automatic do_reset();
    idle();
    bus.upd_ready_i = 0;
    reset_i = 1;
    tick(); tick();
    reset_i = 0;
  endtask

  task automatic enq(input logic [W-1:0] idx, input logic tk);
    bus.pred_v_i = 1; bus.pred_idx_i = idx; bus.pred_taken_i = tk;
  endtask

  task automatic res(input int id, input logic tk);
    bus.res_v_i = 1; bus.res_id_i = id[2:0]; bus.res_taken_i = tk;
  endtask

  initial begin
    reset_i = 1;
    idle();
    bus.upd_ready_i = 0;
    do_reset();

    // Reset values
    chk("rst_ready", bus.pred_ready_o, 1);
    chk("rst_id", bus.pred_id_o, 0);
    chk("rst_upd_v", bus.upd_v_o, 0);
    chk("rst_upd_idx", bus.upd_idx_o, 0);
    chk("rst_correct", bus.upd_correct_o, 0);
    chk("rst_pred_tk", bus.upd_pred_taken_o, 0);
    chk("rst_count", bus.count_o, 0);

    // 1. Fill and full; pred_taken alternates 0,1,...
    for (int i = 0; i < 8; i++) begin
      enq(8'h10 + 8'(i), i[0]);
      chk("fill_id", bus.pred_id_o, i);
      tick();
    end
    idle();
    chk("full_ready", bus.pred_ready_o, 0);
    chk("full_count", bus.count_o, 8);
    enq(8'h55, 1'b1);
    tick();
    idle();
    chk("full_noenq_count", bus.count_o, 8);

    // 2. Out-of-order resolves, all correct
    res(2, 0); tick(); idle();
    chk("ooo_r2_v", bus.upd_v_o, 0);
    res(1, 1); tick(); idle();
    chk("ooo_r1_v", bus.upd_v_o, 0);
    res(0, 0); tick(); idle();
    chk("ooo_r0_v", bus.upd_v_o, 1);
    chk("ooo_r0_idx", bus.upd_idx_o, 8'h10);
    chk("ooo_r0_ok", bus.upd_correct_o, 1);
    chk("ooo_r0_ptk", bus.upd_pred_taken_o, 0);
    bus.upd_ready_i = 1;
    tick();
    chk("ooo_r1_v2", bus.upd_v_o, 1);
    chk("ooo_r1_idx", bus.upd_idx_o, 8'h11);
    chk("ooo_r1_ok", bus.upd_correct_o, 1);
    chk("ooo_r1_ptk", bus.upd_pred_taken_o, 1);
    tick();
    chk("ooo_r2_idx", bus.upd_idx_o, 8'h12);
    chk("ooo_r2_ok", bus.upd_correct_o, 1);
    tick();
    chk("ooo_stall_v", bus.upd_v_o, 0);
    chk("ooo_count", bus.count_o, 5);
    bus.upd_ready_i = 0;

    // 3. Mispredict squash with a same-cycle enqueue
    do_reset();
    for (int i = 0; i < 5; i++) begin
      enq(8'h20 + 8'(i), 1'b0);
      tick();
    end
    enq(8'h2f, 1'b1);
    res(1, 1);
    tick(); idle();
    chk("mp_count", bus.count_o, 2);
    chk("mp_id", bus.pred_id_o, 2);
    chk("mp_ready", bus.pred_ready_o, 1);
    chk("mp_v", bus.upd_v_o, 0);
    res(0, 0); tick(); idle();
    chk("mp_h_v", bus.upd_v_o, 1);
    chk("mp_h_idx", bus.upd_idx_o, 8'h20);
    chk("mp_h_ok", bus.upd_correct_o, 1);
    bus.upd_ready_i = 1;
    tick();
    chk("mp_1_v", bus.upd_v_o, 1);
    chk("mp_1_idx", bus.upd_idx_o, 8'h21);
    chk("mp_1_ok", bus.upd_correct_o, 0);
    chk("mp_1_ptk", bus.upd_pred_taken_o, 0);
    tick();
    chk("mp_drain_v", bus.upd_v_o, 0);
    chk("mp_drain_count", bus.count_o, 0);
    bus.upd_ready_i = 0;

    // 4. Wrap-around mispredict: advance head to 6, then queue ids 6,7,0,1
    do_reset();
    for (int i = 0; i < 6; i++) begin
      enq(8'h30 + 8'(i), 1'b0);
      tick();
    end
    idle();
    bus.upd_ready_i = 1;
    for (int k = 0; k < 6; k++) begin
      res(k, 0);
      tick();
    end
    idle();
    tick();
    bus.upd_ready_i = 0;
    chk("wr_empty", bus.count_o, 0);
    chk("wr_tail", bus.pred_id_o, 6);
    for (int i = 0; i < 4; i++) begin
      enq(8'h40 + 8'(i), 1'b1);
      chk("wr_id", bus.pred_id_o, (6 + i) % 8);
      tick();
    end
    idle();
    chk("wr_count4", bus.count_o, 4);
    res(7, 0); tick(); idle();
    chk("wr_mp_count", bus.count_o, 2);
    chk("wr_mp_id", bus.pred_id_o, 0);
    chk("wr_mp_ready", bus.pred_ready_o, 1);
    res(6, 1);
    bus.upd_ready_i = 1;
    tick(); idle();
    chk("wr_6_idx", bus.upd_idx_o, 8'h40);
    chk("wr_6_ok", bus.upd_correct_o, 1);
    tick();
    chk("wr_7_v", bus.upd_v_o, 1);
    chk("wr_7_idx", bus.upd_idx_o, 8'h41);
    chk("wr_7_ok", bus.upd_correct_o, 0);
    chk("wr_7_ptk", bus.upd_pred_taken_o, 1);
    tick();
    chk("wr_drain", bus.count_o, 0);
    bus.upd_ready_i = 0;

    // 5. Flush under backpressure; same-cycle enqueue and resolve are dropped
    enq(8'h50, 1'b0); tick();
    enq(8'h51, 1'b0); tick(); idle();
    res(0, 0); tick(); idle();
    chk("fl_pre_v", bus.upd_v_o, 1);
    chk("fl_pre_idx", bus.upd_idx_o, 8'h50);
    tick();
    chk("fl_hold_v", bus.upd_v_o, 1);
    bus.flush_i = 1;
    enq(8'h5a, 1'b1);
    res(1, 0);
    tick(); idle();
    chk("fl_v", bus.upd_v_o, 0);
    chk("fl_count", bus.count_o, 0);
    chk("fl_id", bus.pred_id_o, 0);
    chk("fl_ready", bus.pred_ready_o, 1);
    tick();
    chk("fl_v_later", bus.upd_v_o, 0);

    // 6. Invalid resolves: empty slot, not-yet-occupied slot, double resolve
    res(3, 1); tick(); idle();
    chk("inv_empty_count", bus.count_o, 0);
    chk("inv_empty_v", bus.upd_v_o, 0);
    enq(8'h60, 1'b1);
    res(0, 1);
    tick(); idle();
    chk("inv_early_count", bus.count_o, 1);
    chk("inv_early_v", bus.upd_v_o, 0);
    res(0, 1); tick(); idle();
    chk("inv_first_v", bus.upd_v_o, 1);
    chk("inv_first_ok", bus.upd_correct_o, 1);
    res(0, 0); tick(); idle();
    chk("inv_second_ok", bus.upd_correct_o, 1);
    chk("inv_second_count", bus.count_o, 1);
    chk("inv_second_idx", bus.upd_idx_o, 8'h60);
    bus.upd_ready_i = 1;
    tick();
    bus.upd_ready_i = 0;
    chk("inv_drain_count", bus.count_o, 0);
    chk("inv_drain_v", bus.upd_v_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
